collision_checker: RTL and testbench

COLLISION_CHECKER -- requirements
Module: collision_checker

---
 rtl/tetris_pkg.sv | 26 ++
 rtl/collision_checker.sv | 145 ++++++++++++++
 tb/tb_collision_checker.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared playfield definitions: board size defaults, cell codes and checker FSM encoding.
// Pure declarations, no logic; imported by the collision checker and its neighbours.
package tetris_pkg;

  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;

  typedef enum logic [2:0] {
    CELL_EMPTY = 3'd0,
    CELL_L     = 3'd1,
    CELL_J     = 3'd2,
    CELL_S     = 3'd3,
    CELL_Z     = 3'd4,
    CELL_O     = 3'd5,
    CELL_I     = 3'd6,
    CELL_T     = 3'd7
  } cell_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

endpackage

// File: rtl/collision_checker.sv
// Checks a 4-cell piece against board bounds and occupancy; result valid 6 cycles after accept.
// Backpressure: req_ready low while busy, requests outside IDLE are dropped, not queued.
module collision_checker
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] cx0,
  input  logic [3:0] cx1,
  input  logic [3:0] cx2,
  input  logic [3:0] cx3,
  input  logic [5:0] cy0,
  input  logic [5:0] cy1,
  input  logic [5:0] cy2,
  input  logic [5:0] cy3,
  input  logic       req_valid,
  output logic       req_ready,
  output logic       rd_en,
  output logic [3:0] rd_x,
  output logic [5:0] rd_y,
  input  logic [2:0] rd_data,
  output logic       done,
  output logic       collide,
  output logic       oob
);

  // Upstream wraps negative offsets, so a plain unsigned compare catches both edges.
  function automatic logic in_bounds(input logic [3:0] x, input logic [5:0] y);
    return (int'(x) < BOARD_W) && (int'(y) < BOARD_H);
  endfunction

  chk_state_t state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [3:0] cx_q [4];
  logic [3:0] cx_d [4];
  logic [5:0] cy_q [4];
  logic [5:0] cy_d [4];
  logic       sc_collide_q, sc_collide_d;
  logic       sc_oob_q, sc_oob_d;
  logic       rd_pend_q, rd_pend_d;
  logic       done_q, done_d;
  logic       collide_q, collide_d;
  logic       oob_q, oob_d;
  logic [3:0] cur_x;
  logic [5:0] cur_y;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    sc_collide_d = sc_collide_q;
    sc_oob_d     = sc_oob_q;
    rd_pend_d    = 1'b0;
    done_d       = 1'b0;
    collide_d    = collide_q;
    oob_d        = oob_q;
    req_ready    = 1'b0;
    rd_en        = 1'b0;
    rd_x         = '0;
    rd_y         = '0;
    cur_x        = cx_q[k_q];
    cur_y        = cy_q[k_q];

    // Board data answers the read issued on the previous cycle.
    if (rd_pend_q && (rd_data != CELL_EMPTY)) begin
      sc_collide_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cx_d         = '{cx0, cx1, cx2, cx3};
          cy_d         = '{cy0, cy1, cy2, cy3};
          sc_collide_d = 1'b0;
          sc_oob_d     = 1'b0;
          k_d          = 2'd0;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        if (in_bounds(cur_x, cur_y)) begin
          rd_en     = 1'b1;
          rd_x      = cur_x;
          rd_y      = cur_y;
          rd_pend_d = 1'b1;
        end else begin
          sc_oob_d     = 1'b1;
          sc_collide_d = 1'b1;
        end
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        done_d    = 1'b1;
        collide_d = sc_collide_q;
        oob_d     = sc_oob_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      k_q          <= 2'd0;
      sc_collide_q <= 1'b0;
      sc_oob_q     <= 1'b0;
      rd_pend_q    <= 1'b0;
      done_q       <= 1'b0;
      collide_q    <= 1'b0;
      oob_q        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cx_q[i] <= '0;
        cy_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      sc_collide_q <= sc_collide_d;
      sc_oob_q     <= sc_oob_d;
      rd_pend_q    <= rd_pend_d;
      done_q       <= done_d;
      collide_q    <= collide_d;
      oob_q        <= oob_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
    end
  end

  assign done    = done_q;
  assign collide = collide_q;
  assign oob     = oob_q;

endmodule

// File: tb/tb_collision_checker.sv
// Directed vector bench for collision_checker with a one-cell board model.
module tb_collision_checker;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] cx0 = '0, cx1 = '0, cx2 = '0, cx3 = '0;
  logic [5:0] cy0 = '0, cy1 = '0, cy2 = '0, cy3 = '0;
  logic       req_valid = 1'b0;
  logic       req_ready, rd_en, done, collide, oob;
  logic [3:0] rd_x;
  logic [5:0] rd_y;
  logic [2:0] rd_data = '0;

  int n_cmp = 0;
  int n_err = 0;
  int rd_total = 0;
  int addr_err = 0;

  // single occupied cell of the modelled board
  logic       occ_vld = 1'b0;
  logic [3:0] occ_x = '0;
  logic [5:0] occ_y = '0;
  logic [2:0] occ_code = '0;

  always #5 clk = ~clk;

  collision_checker #(.BOARD_W(10), .BOARD_H(20)) dut (
    .clk(clk), .reset_n(reset_n),
    .cx0(cx0), .cx1(cx1), .cx2(cx2), .cx3(cx3),
    .cy0(cy0), .cy1(cy1), .cy2(cy2), .cy3(cy3),
    .req_valid(req_valid), .req_ready(req_ready),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .done(done), .collide(collide), .oob(oob)
  );

  function automatic logic [2:0] board_at(input logic [3:0] x, input logic [5:0] y);
    return (occ_vld && x == occ_x && y == occ_y) ? occ_code : 3'd0;
  endfunction

  // Board RAM: one-cycle read latency; garbage when not read so stale data is noticed.
  always @(posedge clk) rd_data <= rd_en ? board_at(rd_x, rd_y) : 3'd7;

  always @(negedge clk) begin
    if (rd_en) rd_total++;
    if (!rd_en && (rd_x != 0 || rd_y != 0)) addr_err++;
    if (rd_en && (rd_x >= 4'd10 || rd_y >= 6'd20)) addr_err++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0][3:0] x;
    logic [3:0][5:0] y;
    logic            ov;
    logic [3:0]      ox;
    logic [5:0]      oy;
    logic [2:0]      oc;
    logic            ec;
    logic            eo;
    logic [2:0]      er;
  } vec_t;

  function automatic vec_t mk(input int x0, y0, x1, y1, x2, y2, x3, y3,
                              input int ov, ox, oy, oc, ec, eo, er);
    vec_t v;
    v.x[0] = 4'(x0); v.y[0] = 6'(y0);
    v.x[1] = 4'(x1); v.y[1] = 6'(y1);
    v.x[2] = 4'(x2); v.y[2] = 6'(y2);
    v.x[3] = 4'(x3); v.y[3] = 6'(y3);
    v.ov = 1'(ov); v.ox = 4'(ox); v.oy = 6'(oy); v.oc = 3'(oc);
    v.ec = 1'(ec); v.eo = 1'(eo); v.er = 3'(er);
    return v;
  endfunction

  vec_t vecs [9];

  task automatic drive_cells(input vec_t v);
    cx0 = v.x[0]; cx1 = v.x[1]; cx2 = v.x[2]; cx3 = v.x[3];
    cy0 = v.y[0]; cy1 = v.y[1]; cy2 = v.y[2]; cy3 = v.y[3];
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int lat;
    int rd0;
    v = vecs[idx];
    @(negedge clk);
    occ_vld = v.ov; occ_x = v.ox; occ_y = v.oy; occ_code = v.oc;
    drive_cells(v);
    req_valid = 1'b1;
    chk($sformatf("v%0d_ready_idle", idx), int'(req_ready), 1);
    rd0 = rd_total;
    @(posedge clk); #1;
    req_valid = 1'b0;
    // scramble inputs after acceptance: all wrapped-negative cells
    cx0 = 4'hf; cx1 = 4'hf; cx2 = 4'hf; cx3 = 4'hf;
    cy0 = 6'h3f; cy1 = 6'h3f; cy2 = 6'h3f; cy3 = 6'h3f;
    chk($sformatf("v%0d_ready_busy", idx), int'(req_ready), 0);
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk($sformatf("v%0d_latency", idx), lat, 6);
    chk($sformatf("v%0d_collide", idx), int'(collide), int'(v.ec));
    chk($sformatf("v%0d_oob", idx), int'(oob), int'(v.eo));
    chk($sformatf("v%0d_reads", idx), rd_total - rd0, int'(v.er));
    @(posedge clk); #1;
    chk($sformatf("v%0d_done_pulse", idx), int'(done), 0);
    chk($sformatf("v%0d_collide_hold", idx), int'(collide), int'(v.ec));
  endtask

  initial begin
    int dn;
    int acc;
    int acc_at [3];

    //              x0 y0  x1 y1  x2 y2  x3 y3  ov ox oy oc  ec eo rd
    vecs[0] = mk(4, 0,  5, 0,  3, 0,  6, 0,   0, 0, 0, 0,  0, 0, 4);
    vecs[1] = mk(4, 10, 5, 10, 3, 10, 4, 11,  1, 5, 10, 3, 1, 0, 4);
    vecs[2] = mk(0, 5,  15, 5, 1, 5,  0, 6,   0, 0, 0, 0,  1, 1, 3);
    vecs[3] = mk(4, 20, 5, 19, 3, 19, 4, 18,  0, 0, 0, 0,  1, 1, 3);
    vecs[4] = mk(0, 19, 9, 19, 1, 19, 2, 19,  0, 0, 0, 0,  0, 0, 4);
    vecs[5] = mk(10, 0, 9, 0,  8, 0,  7, 0,   0, 0, 0, 0,  1, 1, 3);
    vecs[6] = mk(6, 19, 7, 19, 8, 19, 9, 19,  1, 9, 19, 7, 1, 0, 4);
    vecs[7] = mk(0, 0,  0, 1,  0, 2,  0, 3,   1, 0, 0, 1,  1, 0, 4);
    vecs[8] = mk(0, 63, 1, 63, 2, 63, 3, 63,  0, 0, 0, 0,  1, 1, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({done, collide, oob, rd_en, rd_x, rd_y}), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", int'(req_ready), 1);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Reset three edges into a scan, right after a colliding result.
    run_vec(1);
    @(negedge clk);
    occ_vld = 1'b0;
    drive_cells(vecs[2]);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset_outputs", int'({done, collide, oob, rd_en, rd_x, rd_y}), 0);
    chk("midreset_ready", int'(req_ready), 1);
    reset_n = 1'b1;
    dn = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("midreset_no_done", dn, 0);
    chk("midreset_collide", int'(collide), 0);
    run_vec(0);

    // req_valid held high for 20 cycles
    @(negedge clk);
    occ_vld = 1'b0;
    drive_cells(vecs[0]);
    req_valid = 1'b1;
    acc = 0;
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        if (acc < 3) acc_at[acc] = i;
        acc++;
      end
      if (done) dn++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("b2b_accepts", acc, 3);
    chk("b2b_dones", dn, 3);
    if (acc >= 3) begin
      chk("b2b_gap1", acc_at[1] - acc_at[0], 7);
      chk("b2b_gap2", acc_at[2] - acc_at[1], 7);
    end
    chk("b2b_collide", int'(collide), 0);

    chk("read_addr_rules", addr_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
